// File: rtl/wash_pkg.sv
// Shared encodings for the wash sequencer: phase/stage codes, motor codes
// and the size multiplier derived from the mode switches.
package wash_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_FILL    = 3'd1,
    PH_AGITATE = 3'd2,
    PH_DRAIN   = 3'd3,
    PH_SPIN    = 3'd4,
    PH_DONE    = 3'd5
  } phase_t;

  typedef enum logic [1:0] {
    ST_NONE  = 2'd0,
    ST_WASH  = 2'd1,
    ST_RINSE = 2'd2,
    ST_SPIN  = 2'd3
  } stage_t;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_FWD  = 2'b01;
  localparam logic [1:0] MOTOR_REV  = 2'b10;

  // Load size k: 0 means spin-only, 1..3 scale the agitate phases.
  function automatic logic [1:0] k_of_mode(input logic [1:0] mode);
    case (mode)
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      2'b11:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/wash_seq_gen_if.sv
// Switch-side inputs and display/LED-side outputs of the wash sequencer.
// start/pause are levels, abort is a one-cycle pulse, done is a one-cycle pulse; there is no back-pressure.
interface wash_seq_gen_if #(
  parameter int LEVEL_W = 8,
  parameter int REM_W   = 10
);
  logic               start;
  logic [1:0]         mode;
  logic               pause;
  logic               abort;
  logic [2:0]         phase;
  logic [1:0]         stage;
  logic [1:0]         rinse_idx;
  logic [1:0]         motor;
  logic               valve_in;
  logic               valve_out;
  logic [LEVEL_W-1:0] level;
  logic [REM_W-1:0]   rem_sec;
  logic               busy;
  logic               done;

  modport master (
    output start, mode, pause, abort,
    input  phase, stage, rinse_idx, motor, valve_in, valve_out, level, rem_sec, busy, done
  );

  modport slave (
    input  start, mode, pause, abort,
    output phase, stage, rinse_idx, motor, valve_in, valve_out, level, rem_sec, busy, done
  );
endinterface

// File: rtl/sec_tick_gen.sv
// One-second tick divider; counts only while enabled and restarts a full second on clr.
module sec_tick_gen #(
  parameter int CLK_PER_SEC = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLK_PER_SEC);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(CLK_PER_SEC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wash_seq_gen.sv
// Parametrised wash-cycle sequencer: fill/agitate/drain per wash and rinse, then spin,
// with pause, abort-with-drain and a remaining-seconds counter. Outputs are registered.
module wash_seq_gen
  import wash_pkg::*;
#(
  parameter int CLK_PER_SEC = 100000000,
  parameter int LEVEL_W     = 8,
  parameter int N_RINSE     = 1,
  parameter int WASH_UNIT   = 10,
  parameter int RINSE_UNIT  = 10,
  parameter int SPIN_T      = 15,
  parameter int REM_W       = 10
) (
  input logic           clk,
  input logic           rst,
  wash_seq_gen_if.slave bus
);
  localparam int AG_MAX    = 3 * ((WASH_UNIT > RINSE_UNIT) ? WASH_UNIT : RINSE_UNIT);
  localparam int T_MAX     = (AG_MAX > SPIN_T) ? AG_MAX : SPIN_T;
  localparam int TMR_W     = $clog2(T_MAX + 1);
  localparam int RUN_BASE  = 2 * LEVEL_W * (1 + N_RINSE) + SPIN_T;
  localparam int RUN_PER_K = WASH_UNIT + N_RINSE * RINSE_UNIT;

  phase_t             phase_q, phase_d;
  stage_t             stage_q, stage_d;
  logic [1:0]         rinse_q, rinse_d, k_q, k_d, motor_q, motor_d;
  logic               valve_in_q, valve_in_d, valve_out_q, valve_out_d;
  logic               busy_q, busy_d, done_q, done_d, abrt_q, abrt_d;
  logic [LEVEL_W-1:0] level_q, level_d, lvl_up, lvl_dn;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [TMR_W-1:0]   timer_q, timer_d, agit_last;
  logic               accept, tick, div_clr;

  assign accept    = bus.start && (phase_q == PH_IDLE || phase_q == PH_DONE);
  assign div_clr   = accept || (bus.abort && busy_q);
  assign lvl_up    = (level_q << 1) | LEVEL_W'(1);
  assign lvl_dn    = level_q >> 1;
  assign agit_last = TMR_W'(int'(k_q) * ((stage_q == ST_RINSE) ? RINSE_UNIT : WASH_UNIT) - 1);

  sec_tick_gen #(.CLK_PER_SEC(CLK_PER_SEC)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_q && !bus.pause),
    .clr  (div_clr),
    .tick (tick)
  );

  always_comb begin
    phase_d = phase_q;
    stage_d = stage_q;
    rinse_d = rinse_q;
    k_d     = k_q;
    level_d = level_q;
    rem_d   = rem_q;
    timer_d = timer_q;
    abrt_d  = abrt_q;
    done_d  = 1'b0;
    if (accept) begin
      k_d     = k_of_mode(bus.mode);
      rinse_d = 2'd0;
      level_d = '0;
      timer_d = '0;
      abrt_d  = 1'b0;
      if (bus.mode == 2'b00) begin
        phase_d = PH_SPIN;
        stage_d = ST_SPIN;
        rem_d   = REM_W'(SPIN_T);
      end else begin
        phase_d = PH_FILL;
        stage_d = ST_WASH;
        rem_d   = REM_W'(RUN_BASE + int'(k_of_mode(bus.mode)) * RUN_PER_K);
      end
    end else if (bus.abort && busy_q) begin
      timer_d = '0;
      if (phase_q == PH_SPIN) begin
        phase_d = PH_IDLE;
        stage_d = ST_NONE;
        rinse_d = 2'd0;
        rem_d   = '0;
      end else begin
        // Never leave water in the drum: drain whatever is there, one second per bar.
        phase_d = PH_DRAIN;
        abrt_d  = 1'b1;
        rem_d   = REM_W'($countones(level_q));
      end
    end else if (tick) begin
      rem_d = (rem_q == '0) ? '0 : rem_q - REM_W'(1);
      case (phase_q)
        PH_FILL: begin
          level_d = lvl_up;
          if (&lvl_up) phase_d = PH_AGITATE;
        end
        PH_AGITATE: begin
          timer_d = timer_q + TMR_W'(1);
          if (timer_q == agit_last) begin
            phase_d = PH_DRAIN;
            timer_d = '0;
          end
        end
        PH_DRAIN: begin
          level_d = lvl_dn;
          if (lvl_dn == '0) begin
            if (abrt_q) begin
              phase_d = PH_IDLE;
              stage_d = ST_NONE;
              rinse_d = 2'd0;
              abrt_d  = 1'b0;
            end else if (int'(rinse_q) < N_RINSE) begin
              phase_d = PH_FILL;
              stage_d = ST_RINSE;
              rinse_d = rinse_q + 2'd1;
            end else begin
              phase_d = PH_SPIN;
              stage_d = ST_SPIN;
              rinse_d = 2'd0;
            end
          end
        end
        PH_SPIN: begin
          timer_d = timer_q + TMR_W'(1);
          if (timer_q == TMR_W'(SPIN_T - 1)) begin
            phase_d = PH_DONE;
            stage_d = ST_NONE;
            timer_d = '0;
            rem_d   = '0;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Actuators follow the next phase, but are all off while paused.
    motor_d     = MOTOR_STOP;
    valve_in_d  = 1'b0;
    valve_out_d = 1'b0;
    if (!bus.pause) begin
      case (phase_d)
        PH_FILL:    valve_in_d = 1'b1;
        PH_AGITATE: motor_d = timer_d[0] ? MOTOR_REV : MOTOR_FWD;
        PH_DRAIN:   valve_out_d = 1'b1;
        PH_SPIN: begin
          motor_d     = MOTOR_FWD;
          valve_out_d = 1'b1;
        end
        default: ;
      endcase
    end
    busy_d = phase_d inside {PH_FILL, PH_AGITATE, PH_DRAIN, PH_SPIN};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PH_IDLE;
      stage_q     <= ST_NONE;
      rinse_q     <= 2'd0;
      k_q         <= 2'd0;
      level_q     <= '0;
      rem_q       <= '0;
      timer_q     <= '0;
      abrt_q      <= 1'b0;
      done_q      <= 1'b0;
      motor_q     <= MOTOR_STOP;
      valve_in_q  <= 1'b0;
      valve_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      stage_q     <= stage_d;
      rinse_q     <= rinse_d;
      k_q         <= k_d;
      level_q     <= level_d;
      rem_q       <= rem_d;
      timer_q     <= timer_d;
      abrt_q      <= abrt_d;
      done_q      <= done_d;
      motor_q     <= motor_d;
      valve_in_q  <= valve_in_d;
      valve_out_q <= valve_out_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.stage     = stage_q;
  assign bus.rinse_idx = rinse_q;
  assign bus.motor     = motor_q;
  assign bus.valve_in  = valve_in_q;
  assign bus.valve_out = valve_out_q;
  assign bus.level     = level_q;
  assign bus.rem_sec   = rem_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_wash_seq_gen.sv
// Bench for wash_seq_gen: table of whole runs, random start/mode/pause against a
// segment-schedule model, and hand-written abort/reset/re-accept sequences.
module tb_wash_seq_gen;
  import wash_pkg::*;

  localparam int CPS = 4;
  localparam int LW  = 4;
  localparam int NR  = 1;
  localparam int WU  = 3;
  localparam int RU  = 2;
  localparam int SPT = 3;
  localparam int RW  = 10;

  typedef struct packed {
    logic [2:0]    phase;
    logic [1:0]    stage;
    logic [1:0]    rinse;
    logic [1:0]    motor;
    logic          vin;
    logic          vout;
    logic [LW-1:0] level;
    logic [RW-1:0] rem;
    logic          busy;
    logic          done;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  typedef struct { int ph; int stg; int rin; int secs; } seg_t;
  typedef struct { int mode; int pause_at; int pause_len; int exp_rem; int exp_done; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wash_seq_gen_if #(.LEVEL_W(LW), .REM_W(RW)) bus ();

  wash_seq_gen #(
    .CLK_PER_SEC(CPS), .LEVEL_W(LW), .N_RINSE(NR), .WASH_UNIT(WU),
    .RINSE_UNIT(RU), .SPIN_T(SPT), .REM_W(RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: a run is a list of (phase, stage, rinse, seconds) segments;
  // m_t counts active (busy, unpaused) clocks since accept.
  seg_t segs[$];
  int m_state = 0;  // 0 idle, 1 running, 2 done
  int m_t, m_total, m_pp, m_pulse, m_done_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic void add_seg(input int ph, input int stg, input int rin, input int secs);
    seg_t sg;
    sg.ph = ph; sg.stg = stg; sg.rin = rin; sg.secs = secs;
    segs.push_back(sg);
  endfunction

  function automatic void build(input int mode);
    segs.delete();
    if (mode == 0) add_seg(4, 3, 0, SPT);
    else begin
      add_seg(1, 1, 0, LW); add_seg(2, 1, 0, mode * WU); add_seg(3, 1, 0, LW);
      for (int r = 1; r <= NR; r++) begin
        add_seg(1, 2, r, LW); add_seg(2, 2, r, mode * RU); add_seg(3, 2, r, LW);
      end
      add_seg(4, 3, 0, SPT);
    end
    m_total = 0;
    foreach (segs[i]) m_total += segs[i].secs;
  endfunction

  function automatic void model_update(input logic start, input logic [1:0] mode, input logic pause);
    if (start && m_state != 1) begin
      build(int'(mode));
      m_t = 0; m_state = 1; m_pulse = 0;
    end else if (m_state == 1) begin
      if (!pause) m_t++;
      if (m_t == m_total * CPS) begin
        m_state = 2; m_pulse = 1; m_done_cnt++;
      end
    end else m_pulse = 0;
    m_pp = int'(pause);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int s, base, j;
    e = '0;
    if (m_state == 2) begin
      e.phase = 3'd5;
      e.done  = (m_pulse != 0);
    end else if (m_state == 1) begin
      s = m_t / CPS;
      e.busy = 1'b1;
      e.rem  = RW'(m_total - s);
      base = 0;
      foreach (segs[i]) begin
        if (s >= base && s < base + segs[i].secs) begin
          j = s - base;
          e.phase = 3'(segs[i].ph);
          e.stage = 2'(segs[i].stg);
          e.rinse = 2'(segs[i].rin);
          case (segs[i].ph)
            1: begin e.level = LW'((1 << j) - 1); e.vin = (m_pp == 0); end
            2: begin e.level = '1; e.motor = (m_pp != 0) ? 2'b00 : ((j % 2 == 1) ? 2'b10 : 2'b01); end
            3: begin e.level = LW'((1 << (LW - j)) - 1); e.vout = (m_pp == 0); end
            default: begin e.motor = (m_pp != 0) ? 2'b00 : 2'b01; e.vout = (m_pp == 0); end
          endcase
        end
        base += segs[i].secs;
      end
    end
    return e;
  endfunction

  task automatic compare(input exp_t e);
    chk("phase", int'(bus.phase), int'(e.phase));
    chk("stage", int'(bus.stage), int'(e.stage));
    chk("rinse_idx", int'(bus.rinse_idx), int'(e.rinse));
    chk("motor", int'(bus.motor), int'(e.motor));
    chk("valve_in", int'(bus.valve_in), int'(e.vin));
    chk("valve_out", int'(bus.valve_out), int'(e.vout));
    chk("level", int'(bus.level), int'(e.level));
    chk("rem_sec", int'(bus.rem_sec), int'(e.rem));
    chk("busy", int'(bus.busy), int'(e.busy));
    chk("done", int'(bus.done), int'(e.done));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    if (chk_en) begin
      model_update(bus.start, bus.mode, bus.pause);
      exp_q.push_back(model_out());
    end
    #1;
    if (chk_en && exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      compare(e);
    end
  endtask

  task automatic do_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = 0; m_pp = 0; m_pulse = 0;
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[4];
  int acc, dcyc, r, ndone, dut_done;

  initial begin
    vecs[0] = '{1, -1, 0, 24, 96};
    vecs[1] = '{0, -1, 0, 3, 12};
    vecs[2] = '{3, 20, 10, 34, 146};
    vecs[3] = '{2, 30, 5, 29, 121};
    m_done_cnt = 0;
    bus.start = 1'b0; bus.mode = 2'b00; bus.pause = 1'b0; bus.abort = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_stage", int'(bus.stage), 0);
    chk("rst_motor", int'(bus.motor), 0);
    chk("rst_valves", int'({bus.valve_in, bus.valve_out}), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_rem", int'(bus.rem_sec), 0);
    chk("rst_busy_done", int'({bus.busy, bus.done}), 0);
    rst = 1'b0;
    m_state = 0; m_pp = 0;
    chk_en = 1'b1;

    // Whole runs from a table, model also checking every cycle.
    for (int v = 0; v < 4; v++) begin
      bus.mode = 2'(vecs[v].mode);
      bus.start = 1'b1;
      step();
      acc = cyc;
      bus.start = 1'b0;
      chk("rem_at_accept", int'(bus.rem_sec), vecs[v].exp_rem);
      dcyc = -1; r = 0;
      while (dcyc < 0 && r < 400) begin
        if (r == vecs[v].pause_at) bus.pause = 1'b1;
        if (r == vecs[v].pause_at + vecs[v].pause_len) bus.pause = 1'b0;
        step();
        r++;
        if (bus.pause && r > vecs[v].pause_at) chk("motor_paused", int'(bus.motor), 0);
        if (bus.done) dcyc = cyc;
      end
      bus.pause = 1'b0;
      chk("done_cycle", dcyc - acc, vecs[v].exp_done);
      chk("rem_at_done", int'(bus.rem_sec), 0);
      ndone = 0;
      repeat (3) begin step(); ndone += int'(bus.done); end
      chk("done_once", ndone, 0);
      chk("phase_done_hold", int'(bus.phase), 5);
    end

    // Random start/mode/pause traffic.
    dut_done = 0;
    m_done_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 11) == 0);
      bus.mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) bus.pause = ~bus.pause;
      step();
      dut_done += int'(bus.done);
    end
    chk("random_done_count", dut_done, m_done_cnt);
    bus.start = 1'b0; bus.pause = 1'b0;

    // Abort during FILL at level 0011.
    chk_en = 1'b0;
    do_reset();
    bus.mode = 2'b01; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    r = 0;
    while (bus.level != 4'b0011 && r < 40) begin step(); r++; end
    chk("lvl_before_abort", int'(bus.level), 3);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_phase", int'(bus.phase), 3);
    chk("abort_rem", int'(bus.rem_sec), 2);
    ndone = 0;
    for (int i = 0; i < 7; i++) begin step(); ndone += int'(bus.done); end
    chk("abort_still_drain", int'(bus.phase), 3);
    step();
    ndone += int'(bus.done);
    chk("abort_idle", int'(bus.phase), 0);
    chk("abort_level", int'(bus.level), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_no_done", ndone, 0);

    // Abort in IDLE does nothing; abort in SPIN goes straight to IDLE.
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_idle_noop", int'(bus.phase), 0);
    bus.mode = 2'b00; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    chk("spin_phase", int'(bus.phase), 4);
    chk("spin_motor", int'(bus.motor), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_spin_idle", int'(bus.phase), 0);
    chk("abort_spin_motor", int'(bus.motor), 0);
    chk("abort_spin_vout", int'(bus.valve_out), 0);

    // start held through a spin-only run; re-accept right after DONE despite abort.
    bus.mode = 2'b00; bus.start = 1'b1;
    step();
    acc = cyc; dcyc = -1; r = 0;
    while (dcyc < 0 && r < 40) begin
      step();
      r++;
      if (bus.done) dcyc = cyc;
      if (r == 5) chk("no_reaccept_rem", int'(bus.rem_sec), 2);
    end
    chk("held_done_cycle", dcyc - acc, 12);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("reaccept_phase", int'(bus.phase), 4);
    chk("reaccept_rem", int'(bus.rem_sec), 3);
    chk("reaccept_done_low", int'(bus.done), 0);
    bus.start = 1'b0;

    // Asynchronous reset mid-SPIN.
    step();
    rst = 1'b1;
    #1;
    chk("midrst_phase", int'(bus.phase), 0);
    chk("midrst_motor", int'(bus.motor), 0);
    chk("midrst_vout", int'(bus.valve_out), 0);
    chk("midrst_rem", int'(bus.rem_sec), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_stage", int'(bus.stage), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = 0; m_pp = 0; m_pulse = 0;
    exp_q.delete();
    chk_en = 1'b1;
    bus.mode = 2'b01; bus.start = 1'b1;
    step();
    acc = cyc;
    bus.start = 1'b0;
    dcyc = -1; r = 0;
    while (dcyc < 0 && r < 200) begin
      step();
      r++;
      if (bus.done) dcyc = cyc;
    end
    chk("post_reset_done", dcyc - acc, 96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
